seq_div_nb: RTL and testbench

SEQ_DIV_NB -- requirements
Module: seq_div_nb

---
 rtl/seq_div_nb.sv | 156 +++++++++++++++
 tb/tb_seq_div_nb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_nb.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per cycle.
// Divide-by-zero completes in one cycle without entering the iteration loop.
module seq_div_nb #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         sgn,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dvz,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  pr_q, pr_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic          dvz_pend_q, dvz_pend_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          done_q, done_d;
    logic          dvz_q, dvz_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    step_tmp;
    logic [N:0]    step_diff;
    logic          q_bit;
    logic          is_min;
    logic          is_neg1;

    // dvd_q holds the dividend magnitude and fills with quotient bits from the LSB
    assign step_tmp  = {pr_q, dvd_q[N-1]};
    assign step_diff = step_tmp - {1'b0, dvs_q};
    assign q_bit     = ~step_diff[N];
    assign is_min    = (dividend == {1'b1, {(N-1){1'b0}}});
    assign is_neg1   = &divisor;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pr_d       = pr_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        dvz_pend_d = 1'b0;
        quo_d      = quo_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        dvz_d      = dvz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (dvz_pend_q) begin
                    quo_d  = '1;
                    rem_d  = dvd_q;
                    dvz_d  = 1'b1;
                    ovf_d  = 1'b0;
                    done_d = 1'b1;
                end
                if (start) begin
                    if (divisor == '0) begin
                        dvz_pend_d = 1'b1;
                        dvd_d      = dividend;
                    end else begin
                        dvd_d      = (sgn && dividend[N-1]) ? -dividend : dividend;
                        dvs_d      = (sgn && divisor[N-1]) ? -divisor : divisor;
                        qneg_d     = sgn & (dividend[N-1] ^ divisor[N-1]);
                        rneg_d     = sgn & dividend[N-1];
                        ovf_pend_d = sgn & is_min & is_neg1;
                        cnt_d      = '0;
                        pr_d       = '0;
                        state_d    = StCalc;
                    end
                end
            end
            StCalc: begin
                // A failed subtract means step_tmp < divisor, so its top bit is zero
                pr_d  = q_bit ? step_diff[N-1:0] : step_tmp[N-1:0];
                dvd_d = {dvd_q[N-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                quo_d   = qneg_q ? -dvd_q : dvd_q;
                rem_d   = rneg_q ? -pr_q : pr_q;
                dvz_d   = 1'b0;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pr_q       <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            dvz_pend_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            dvz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pr_q       <= pr_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            dvz_pend_q <= dvz_pend_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            dvz_q      <= dvz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign dvz  = dvz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div_nb.sv
// Self-checking bench for seq_div_nb (N=8): directed corner cases plus random
// operands compared against an arithmetic reference model.
module tb_seq_div_nb;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic       sgn;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       dvz;
    logic       ovf;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    seq_div_nb #(.N(8)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .sgn      (sgn),
        .dividend (dividend),
        .divisor  (divisor),
        .quo      (quo),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dvz      (dvz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    task automatic model(input bit s, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output bit z, output bit o);
        int ia;
        int ib;
        z = 1'b0;
        o = 1'b0;
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            if (ia == -128 && ib == -1) begin
                q = 8'h80;
                r = 8'h00;
                o = 1'b1;
            end else begin
                q = 8'(ia / ib);
                r = 8'(ia % ib);
            end
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
        end
    endtask

    task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input bit poke, input string tag);
        logic [7:0] eq;
        logic [7:0] er;
        bit         ez;
        bit         eo;
        int         k;
        bit         saw_busy;
        model(s, a, b, eq, er, ez, eo);
        sgn      = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        k        = 0;
        saw_busy = busy;
        while (done !== 1'b1 && k < 30) begin
            if (poke && k == 3) begin
                start    = 1'b1;
                dividend = 8'h11;
                divisor  = 8'h02;
                sgn      = ~s;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
            if (busy) saw_busy = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_latency"}, k, ez ? 1 : 9);
        chk({tag, "_quo"}, quo, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_dvz"}, dvz, ez);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_busy_seen"}, saw_busy, !ez);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_hold_quo"}, quo, eq);
    endtask

    logic [7:0] ha [0:63];
    logic [7:0] hb [0:63];
    bit         hs [0:63];

    initial begin
        logic [7:0] eq;
        logic [7:0] er;
        bit         ez;
        bit         eo;
        bit         s;
        logic [7:0] a;
        logic [7:0] b;
        int         sel;
        int         last_done;
        int         ndone;
        int         idx;
        bit         seen;

        clr_n    = 1'b0;
        start    = 1'b1;
        sgn      = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quo", quo, 8'h00);
        chk("rst_rem", rem, 8'h00);
        chk("rst_dvz", dvz, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        start = 1'b0;
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b0, 8'd200, 8'd7, 1'b0, "u200_7");
        run_op(1'b1, 8'h9C, 8'd7, 1'b0, "sm100_7");
        run_op(1'b1, 8'd100, 8'hF9, 1'b0, "s100_m7");
        run_op(1'b0, 8'd55, 8'd0, 1'b0, "dvz55");
        run_op(1'b1, 8'h80, 8'hFF, 1'b0, "ovf");
        run_op(1'b0, 8'd200, 8'd7, 1'b1, "ignore_start");

        // Abort mid-calculation: outputs are nonzero beforehand
        sgn      = 1'b0;
        dividend = 8'd99;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_quo", quo, 8'h00);
        chk("abort_rem", rem, 8'h00);
        chk("abort_dvz", dvz, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
        chk("abort_done", done, 1'b0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);

        // Start held high with fresh operands every cycle
        last_done = 0;
        ndone     = 0;
        for (int c = 1; c <= 52; c++) begin
            sgn      = 1'($urandom);
            dividend = 8'($urandom);
            divisor  = 8'($urandom_range(1, 255));
            start    = 1'b1;
            hs[c]    = sgn;
            ha[c]    = dividend;
            hb[c]    = divisor;
            @(posedge clk);
            #1;
            if (done) begin
                if (ndone == 0) chk("b2b_first", c, 10);
                else            chk("b2b_period", c - last_done, 10);
                idx = (c >= 10) ? c - 9 : 1;
                model(hs[idx], ha[idx], hb[idx], eq, er, ez, eo);
                chk("b2b_quo", quo, eq);
                chk("b2b_rem", rem, er);
                chk("b2b_ovf", ovf, eo);
                last_done = c;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 5);
        repeat (12) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom);
            a   = 8'($urandom);
            b   = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 8'd0;
            end else if (sel == 1) begin
                s = 1'b1;
                a = 8'h80;
                b = 8'hFF;
            end else if (sel == 2) begin
                b = $urandom_range(0, 1) ? 8'h01 : 8'hFF;
            end
            run_op(s, a, b, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
